// File: rtl/pipe_stage_buf.sv
// Pipeline stage boundary register: valid/ready handshake, synchronous flush, optional skid slot.
// An empty stage always presents an all-zero payload so downstream decodes it as a NOP bubble.
module pipe_stage_buf #(
  parameter int DATA_W = 32,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] m_q, m_d;
  logic [DATA_W-1:0] s_q, s_d;
  logic              rdy_q, rdy_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic              accept;
  logic              deliver;

  assign out_valid = (state_q != EMPTY);
  assign out_data  = out_valid ? m_q : '0;
  // With the skid slot, in_ready comes straight from a flop: no out_ready -> in_ready path.
  assign in_ready  = reset & ((SKID != 0) ? rdy_q : (~out_valid | out_ready));
  assign accept    = in_valid & in_ready;
  assign deliver   = out_valid & out_ready;
  assign stall_cnt = stall_q;

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    stall_d = stall_q;

    case (state_q)
      EMPTY: begin
        if (accept) begin
          m_d     = in_data;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && deliver) begin
          m_d = in_data;
        end else if (accept) begin
          s_d     = in_data;
          state_d = FULL;
        end else if (deliver) begin
          m_d     = '0;
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (deliver) begin
          m_d     = s_q;
          s_d     = '0;
          state_d = ONE;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase

    if (flush) begin
      state_d = EMPTY;
      m_d     = '0;
      s_d     = '0;
    end

    rdy_d = (state_d != FULL);

    if (out_valid && !out_ready && (stall_q != '1)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= EMPTY;
      // NOTE: payload registers are reset too: an idle stage must show a zero NOP, not stale bits.
      m_q     <= '0;
      s_q     <= '0;
      rdy_q   <= 1'b0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      s_q     <= s_d;
      rdy_q   <= rdy_d;
      stall_q <= stall_d;
    end
  end

  a_bubble_zero: assert property (@(posedge clk) disable iff (!reset)
    !out_valid |-> (out_data == '0));

  a_no_accept_when_full: assert property (@(posedge clk) disable iff (!reset)
    (state_q == FULL) |-> !accept);

  a_single_entry_without_skid: assert property (@(posedge clk) disable iff (!reset)
    (SKID == 0) |-> (state_q != FULL));

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: a skid instance (u0) and a single-entry, 4-bit-counter instance (u1).
// Stimulus pushes accepted payloads into per-instance queues; a negedge monitor pops and compares.
module tb_pipe_stage_buf;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush     [2];
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [31:0] in_data   [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [31:0] out_data  [2];
  logic [15:0] stall0;
  logic [3:0]  stall1;

  int          checks = 0;
  int          errors = 0;

  logic [31:0] exp_q   [2][$];
  int          occ     [2] = '{0, 0};
  int          stall_m [2] = '{0, 0};
  logic        rst_last = 1'b1;

  always #5 clk = ~clk;

  pipe_stage_buf #(.DATA_W(32), .SKID(1), .CNT_W(16)) u0 (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush[0]),
    .in_valid  (in_valid[0]),
    .in_ready  (in_ready[0]),
    .in_data   (in_data[0]),
    .out_valid (out_valid[0]),
    .out_ready (out_ready[0]),
    .out_data  (out_data[0]),
    .stall_cnt (stall0)
  );

  pipe_stage_buf #(.DATA_W(32), .SKID(0), .CNT_W(4)) u1 (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush[1]),
    .in_valid  (in_valid[1]),
    .in_ready  (in_ready[1]),
    .in_data   (in_data[1]),
    .out_valid (out_valid[1]),
    .out_ready (out_ready[1]),
    .out_data  (out_data[1]),
    .stall_cnt (stall1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] stall_of(input int i);
    return (i == 0) ? {16'h0, stall0} : {28'h0, stall1};
  endfunction

  // Record what the upcoming edge accepts, then advance to just after that edge.
  task automatic tick();
    #1;
    for (int i = 0; i < 2; i++) begin
      if (reset && in_valid[i] && in_ready[i] && !flush[i]) exp_q[i].push_back(in_data[i]);
    end
    @(posedge clk);
    #1;
  endtask

  // Reference model: occupancy count, payload FIFO and saturating stall count per instance.
  always @(negedge clk) begin : monitor
    logic exp_rdy;
    logic dlv;
    logic acc;
    int   smax;
    for (int i = 0; i < 2; i++) begin
      smax    = (i == 0) ? 65535 : 15;
      exp_rdy = reset && ((i == 0) ? (!rst_last && occ[i] < 2)
                                   : (occ[i] == 0 || out_ready[i]));
      check($sformatf("u%0d out_valid", i), 32'(out_valid[i]), 32'(occ[i] != 0));
      if (occ[i] == 0) check($sformatf("u%0d bubble data", i), out_data[i], 32'h0);
      check($sformatf("u%0d in_ready", i), 32'(in_ready[i]), 32'(exp_rdy));
      check($sformatf("u%0d stall_cnt", i), stall_of(i), 32'(stall_m[i]));

      if (!reset) begin
        occ[i]     = 0;
        stall_m[i] = 0;
        exp_q[i].delete();
      end else begin
        dlv = (occ[i] != 0) && out_ready[i];
        acc = in_valid[i] && exp_rdy;
        if (dlv) begin
          if (exp_q[i].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL u%0d deliver: got %h, expected no payload pending (t=%0t)",
                     i, out_data[i], $time);
          end else begin
            check($sformatf("u%0d deliver", i), out_data[i], exp_q[i].pop_front());
          end
        end
        if (occ[i] != 0 && !out_ready[i] && stall_m[i] < smax) stall_m[i]++;
        if (flush[i]) begin
          occ[i] = 0;
          exp_q[i].delete();
        end else begin
          occ[i] = occ[i] - int'(dlv) + int'(acc);
        end
      end
    end
    rst_last = !reset;
  end

  initial begin
    logic [31:0] t2 [3];
    t2 = '{32'h11, 32'h22, 32'h33};

    // T1: reset held 3 cycles with a payload offered
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      flush[i]     = 1'b0;
      in_valid[i]  = 1'b1;
      in_data[i]   = 32'hDEAD_BEEF;
      out_ready[i] = 1'b0;
    end
    repeat (3) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        check($sformatf("T1 u%0d out_valid", i), 32'(out_valid[i]), 32'h0);
        check($sformatf("T1 u%0d out_data", i), out_data[i], 32'h0);
        check($sformatf("T1 u%0d in_ready", i), 32'(in_ready[i]), 32'h0);
        check($sformatf("T1 u%0d stall_cnt", i), stall_of(i), 32'h0);
      end
    end
    reset = 1'b1;
    for (int i = 0; i < 2; i++) in_valid[i] = 1'b0;
    tick();
    for (int i = 0; i < 2; i++)
      check($sformatf("T1 u%0d in_ready after release", i), 32'(in_ready[i]), 32'h1);

    // T2: streaming on both instances
    for (int i = 0; i < 2; i++) out_ready[i] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 2; i++) begin
        in_valid[i] = 1'b1;
        in_data[i]  = t2[k];
      end
      #1;
      for (int i = 0; i < 2; i++)
        check($sformatf("T2 u%0d in_ready", i), 32'(in_ready[i]), 32'h1);
      tick();
      for (int i = 0; i < 2; i++)
        check($sformatf("T2 u%0d out_data", i), out_data[i], t2[k]);
    end
    for (int i = 0; i < 2; i++) in_valid[i] = 1'b0;
    tick();

    // T3: skid fill on u0
    out_ready[0] = 1'b0;
    in_valid[0]  = 1'b1;
    in_data[0]   = 32'hA1;
    tick();
    in_data[0] = 32'hA2;
    tick();
    check("T3 in_ready when full", 32'(in_ready[0]), 32'h0);
    in_data[0] = 32'hA3;
    tick();
    tick();
    check("T3 head held", out_data[0], 32'hA1);
    out_ready[0] = 1'b1;
    tick();
    check("T3 second out", out_data[0], 32'hA2);
    tick();
    check("T3 third out", out_data[0], 32'hA3);
    in_valid[0] = 1'b0;
    tick();
    check("T3 drained", 32'(out_valid[0]), 32'h0);
    check("T3 stall_cnt", stall_of(0), 32'd3);

    // T4: flush while full, with a payload offered in the same cycle
    out_ready[0] = 1'b0;
    in_valid[0]  = 1'b1;
    in_data[0]   = 32'hB1;
    tick();
    in_data[0] = 32'hB2;
    tick();
    in_data[0] = 32'hB3;
    flush[0]   = 1'b1;
    tick();
    check("T4 out_valid after flush", 32'(out_valid[0]), 32'h0);
    check("T4 out_data after flush", out_data[0], 32'h0);
    check("T4 in_ready after flush", 32'(in_ready[0]), 32'h1);
    flush[0]     = 1'b0;
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    repeat (3) begin
      tick();
      check("T4 no ghost payload", 32'(out_valid[0]), 32'h0);
    end
    check("T4 stall_cnt kept", stall_of(0), 32'd5);

    // T5: combinational in_ready on u1
    out_ready[1] = 1'b0;
    in_valid[1]  = 1'b1;
    in_data[1]   = 32'hC1;
    tick();
    in_data[1] = 32'hC2;
    #1;
    check("T5 in_ready blocked", 32'(in_ready[1]), 32'h0);
    tick();
    out_ready[1] = 1'b1;
    #1;
    check("T5 in_ready follows out_ready", 32'(in_ready[1]), 32'h1);
    tick();
    check("T5 new payload", out_data[1], 32'hC2);
    in_valid[1] = 1'b0;
    tick();

    // T6: 4-bit stall counter saturation on u1
    out_ready[1] = 1'b0;
    in_valid[1]  = 1'b1;
    in_data[1]   = 32'hD1;
    tick();
    in_valid[1] = 1'b0;
    repeat (20) tick();
    check("T6 stall_cnt saturated", stall_of(1), 32'd15);
    out_ready[1] = 1'b1;
    tick();

    // Randomised traffic on both instances
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 2; i++) begin
        in_valid[i]  = ($urandom_range(0, 9) < 7);
        in_data[i]   = $urandom;
        out_ready[i] = ($urandom_range(0, 9) < 6);
        flush[i]     = ($urandom_range(0, 31) == 0);
      end
      tick();
    end

    for (int i = 0; i < 2; i++) begin
      in_valid[i]  = 1'b0;
      flush[i]     = 1'b0;
      out_ready[i] = 1'b1;
    end
    repeat (4) tick();
    for (int i = 0; i < 2; i++)
      check($sformatf("u%0d all payloads delivered", i), 32'(exp_q[i].size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
